dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single data-memory load/store unit (ld_en/st_en/addr/write_data/read_data/ready interface).
- Port 0 is the CPU core load/store path; port 1 is the debug/loader path (memory preload, result readback).
- Serialises accesses, holds memory enables until ready, and returns a one-cycle ack with read data or an error on timeout.

Parameters:
- AW, 32, address width of request ports and memory port.
- DW, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins contention.
- TIMEOUT, 16, max BUSY cycles waiting for m_ready before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held high with stable p0_we/p0_addr/p0_wdata until p0_ack.
- p0_we  in  1  1 = store, 0 = load.
- p0_addr  in  AW  word address.
- p0_wdata  in  DW  store data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  valid with p0_ack; 1 = timed out.
- p0_rdata  out  DW  load data; valid with p0_ack, held until next port-0 load completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- m_ld_en  out  1  load enable to memory unit.
- m_st_en  out  1  store enable to memory unit.
- m_addr  out  AW  registered access address.
- m_wdata  out  DW  registered store data.
- m_rdata  in  DW  memory read data, valid when m_ready = 1.
- m_ready  in  1  memory completion.
- busy  out  1  high in BUSY and ACK states.
- owner  out  1  port currently or last granted.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs 0, including rdata registers, owner and busy. last_served = 1, so port 0 wins the first contention. Reset mid-access drops m_ld_en/m_st_en immediately; no ack is issued.
- States: IDLE, BUSY, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: FIXED_PRIO = 1 grants port 0. FIXED_PRIO = 0 grants the port != last_served.
  - On grant at an edge: latch addr/wdata into m_addr/m_wdata; set m_ld_en = ~we or m_st_en = we; set owner; clear timeout counter; go to BUSY.
- BUSY:
  - Enables held high every cycle until m_ready is sampled high.
  - At the edge where m_ready = 1: drop enables. For a load, capture m_rdata into the owner's rdata register. Set ack = 1 and err = 0 for the owner, set last_served = owner, go to ACK.
  - Otherwise increment the counter. If TIMEOUT != 0 and the counter reaches TIMEOUT-1: drop enables, set ack = 1 and err = 1, leave rdata unchanged, update last_served, go to ACK.
  - m_ready in the same cycle as timeout expiry counts as success (err = 0).
- ACK: exactly one cycle with ack (and err) high, then IDLE. Requests are not sampled in ACK. The requester must deassert or change req by the end of the ACK cycle.
- Minimum latency with m_ready tied high: enable rises 1 edge after req is sampled; ack high 2 edges after req sampled; next grant 3 edges after. Back-to-back throughput is 1 access per 3 cycles.
- m_ready outside BUSY: ignored.
- Never both m_ld_en and m_st_en high. Never both acks high.
- The non-owner port's request is held pending, with no ack, until granted.
- req dropped during BUSY is a protocol violation; the access still completes and acks.

Test Plan:
- Single load: p0 load addr 0x10, memory returns 0xDEADBEEF with m_ready 2 cycles after m_ld_en -> m_ld_en high 2 cycles, m_addr = 0x10, p0_ack pulse 1 cycle, p0_rdata = 0xDEADBEEF, p0_err = 0, p1 outputs unchanged.
- Contention, FIXED_PRIO = 0: p0 and p1 both request continuously, 4 accesses, m_ready immediate -> grants p0, p1, p0, p1; one ack per access; 3-cycle spacing.
- Contention, FIXED_PRIO = 1: both requesting, p0 re-requests after each ack -> p1 never granted while p0 requests; p1 granted on the first IDLE with p0_req low.
- Timeout: TIMEOUT = 4, p1 store, m_ready never asserted -> m_st_en high 4 cycles, then p1_ack = 1 with p1_err = 1, p1_rdata unchanged, state back to IDLE.
- Ready at expiry: TIMEOUT = 4, m_ready asserted in the 4th BUSY cycle -> p0_err = 0, rdata captured.
- Reset mid-access: rst low during BUSY -> m_ld_en = 0 asynchronously, no ack. After release, port 0 wins a simultaneous request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two load/store requesters onto one memory unit; req->enable 1 edge, m_ready->ack 1 edge.
// Backpressure: the losing port holds its request with no ack until granted; a stalled memory is aborted after TIMEOUT cycles.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic          m_ld_en,
  output logic          m_st_en,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy,
  output logic          owner
);

  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;
  localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);

  typedef enum logic [1:0] { S_IDLE, S_BUSY, S_ACK } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          ld_en_q, ld_en_d;
  logic          st_en_q, st_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          any_req, grant, grant_we, timeout_hit;

  // Round-robin favours the port that was not served last.
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req) begin
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      grant = p1_req;
    end
    grant_we    = grant ? p1_we : p0_we;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST_C);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    ld_en_d  = ld_en_q;
    st_en_d  = st_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = grant;
          addr_d  = grant ? p1_addr : p0_addr;
          wdata_d = grant ? p1_wdata : p0_wdata;
          ld_en_d = ~grant_we;
          st_en_d = grant_we;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // A late m_ready on the expiry cycle still wins over the timeout.
        if (m_ready) begin
          ld_en_d = 1'b0;
          st_en_d = 1'b0;
          if (ld_en_q) begin
            if (owner_q) rdata1_d = m_rdata;
            else         rdata0_d = m_rdata;
          end
          ack_d[owner_q] = 1'b1;
          last_d  = owner_q;
          state_d = S_ACK;
        end else if (timeout_hit) begin
          ld_en_d = 1'b0;
          st_en_d = 1'b0;
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
          last_d  = owner_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      ld_en_q  <= 1'b0;
      st_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ld_en_q  <= ld_en_d;
      st_en_q  <= st_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign p0_ack   = ack_q[0];
  assign p0_err   = err_q[0];
  assign p0_rdata = rdata0_q;
  assign p1_ack   = ack_q[1];
  assign p1_err   = err_q[1];
  assign p1_rdata = rdata1_q;
  assign m_ld_en  = ld_en_q;
  assign m_st_en  = st_en_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

endmodule
